// File: rtl/bpu_update_queue.sv
// Commit-side update queue for the branch predictor: compacts up to NRET retiring
// branch records per cycle into a circular FIFO and drains one per cycle to bpu.

package config_pkg;
    typedef struct packed {
        int unsigned NRET;
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{NRET: 32'd4, PLEN: 32'd32};
endpackage

module bpu_update_queue #(
    parameter config_pkg::cfg_t Cfg   = config_pkg::EmptyCfg,
    parameter int unsigned      DEPTH = 8,
    localparam int unsigned     CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [Cfg.NRET-1:0]               commit_valid_i,
    input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0] commit_pc_i,
    input  logic [Cfg.NRET-1:0][Cfg.PLEN-1:0] commit_target_i,
    input  logic [Cfg.NRET-1:0]               commit_is_cond_i,
    input  logic [Cfg.NRET-1:0]               commit_taken_i,
    input  logic [Cfg.NRET-1:0]               commit_is_call_i,
    input  logic [Cfg.NRET-1:0]               commit_is_ret_i,
    output logic                              commit_ready_o,
    output logic                              update_valid_o,
    input  logic                              update_ready_i,
    output logic [Cfg.PLEN-1:0]               update_pc_o,
    output logic [Cfg.PLEN-1:0]               update_target_o,
    output logic                              update_is_cond_o,
    output logic                              update_taken_o,
    output logic                              update_is_call_o,
    output logic                              update_is_ret_o,
    output logic [CNT_W-1:0]                  occupancy_o,
    output logic                              overflow_o
);

    localparam int unsigned NRET  = Cfg.NRET;
    localparam int unsigned PLEN  = Cfg.PLEN;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PLEN-1:0] pc;
        logic [PLEN-1:0] target;
        logic            is_cond;
        logic            taken;
        logic            is_call;
        logic            is_ret;
    } rec_t;

    rec_t                      mem_q [DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic                      overflow_q;

    logic [CNT_W-1:0]          free_c;
    logic [CNT_W-1:0]          n_wr_c;
    logic [CNT_W-1:0]          count_c;
    logic                      drop_c;
    logic                      pop_c;
    logic [NRET-1:0]           lane_wr_c;
    logic [NRET-1:0][PTR_W-1:0] lane_idx_c;
    rec_t [NRET-1:0]           lane_rec_c;
    rec_t                      head_c;

    // Compact valid lanes into consecutive slots; free space ignores a same-cycle pop
    always_comb begin
        free_c     = CNT_W'(DEPTH) - count_q;
        n_wr_c     = '0;
        drop_c     = 1'b0;
        lane_wr_c  = '0;
        lane_idx_c = '0;
        lane_rec_c = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            lane_rec_c[i] = '{pc:      commit_pc_i[i],
                              target:  commit_target_i[i],
                              is_cond: commit_is_cond_i[i],
                              taken:   commit_taken_i[i],
                              is_call: commit_is_call_i[i],
                              is_ret:  commit_is_ret_i[i]};
            if (commit_valid_i[i]) begin
                if (n_wr_c < free_c) begin
                    lane_wr_c[i]  = 1'b1;
                    lane_idx_c[i] = wr_ptr_q + PTR_W'(n_wr_c);
                    n_wr_c        = n_wr_c + CNT_W'(1);
                end else begin
                    drop_c = 1'b1;
                end
            end
        end
        pop_c   = (count_q != '0) && update_ready_i;
        count_c = count_q + n_wr_c - CNT_W'(pop_c);
    end

    // Record storage is not reset; reads are masked while the queue is empty
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NRET; i++) begin
            if (lane_wr_c[i]) begin
                mem_q[lane_idx_c[i]] <= lane_rec_c[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_c);
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_wr_c);
            count_q  <= count_c;
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        head_c = '0;
        if (count_q != '0) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign commit_ready_o   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NRET);
    assign update_valid_o   = (count_q != '0);
    assign update_pc_o      = head_c.pc;
    assign update_target_o  = head_c.target;
    assign update_is_cond_o = head_c.is_cond;
    assign update_taken_o   = head_c.taken;
    assign update_is_call_o = head_c.is_call;
    assign update_is_ret_o  = head_c.is_ret;
    assign occupancy_o      = count_q;
    assign overflow_o       = overflow_q;

endmodule
